cannon_sched: RTL and testbench

- Sequences the sqrt_p x sqrt_p block-matrix multiply grid through Cannon's algorithm:
  - load of A/B tiles (enable_read),
  - initial skew,
  - per-round multiply (enable_mul), accumulate (enable_sum) and A-right/B-down rotate (enable_shift).
- Sits beside the grid.
- Owns every phase enable so that no two phases overlap.
- Reports busy/done/round to the host.

---
 rtl/cannon_pkg.sv | 22 ++
 rtl/phase_timer.sv | 28 ++
 rtl/cannon_sched.sv | 119 +++++++++++
 tb/tb_cannon_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cannon_pkg.sv
// rtl/cannon_pkg.sv - shared types and constants for the Cannon grid scheduler
package cannon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SKEW,
        ST_MUL,
        ST_SUM,
        ST_SHIFT,
        ST_DONE
    } state_e;

    localparam int DEF_SQRT_P = 2;
    localparam int DEF_N      = 8;

    // Bits needed to hold values 0..v inclusive.
    function automatic int clog2_plus1(input int v);
        return $clog2(v + 1);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable saturating down-counter timing LOAD/SKEW/SHIFT phases
module phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign count   = count_q;
    assign expired = (count_q == '0);

endmodule

// File: rtl/cannon_sched.sv
// rtl/cannon_sched.sv - phase sequencer for Cannon's block-matrix multiply grid
module cannon_sched
    import cannon_pkg::*;
#(
    parameter int  SQRT_P       = DEF_SQRT_P,
    parameter int  READ_CYCLES  = 1,
    parameter int  SHIFT_CYCLES = 1,
    localparam int RW           = clog2_plus1(SQRT_P)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          mul_done,
    input  logic          sum_done,
    output logic          enable_read,
    output logic          clear_acc,
    output logic          enable_skew,
    output logic [RW-1:0] skew_step,
    output logic          enable_mul,
    output logic          enable_sum,
    output logic          enable_shift,
    output logic [RW-1:0] round,
    output logic          busy,
    output logic          done,
    output logic          proto_err
);

    localparam int SKEW_LEN = (SQRT_P > 1) ? SQRT_P - 1 : 1;
    localparam int TMAX_RS  = (READ_CYCLES > SHIFT_CYCLES) ? READ_CYCLES : SHIFT_CYCLES;
    localparam int TMAX     = ((TMAX_RS > SKEW_LEN) ? TMAX_RS : SKEW_LEN) - 1;
    localparam int TW       = (TMAX < 1) ? 1 : clog2_plus1(TMAX);

    localparam logic [TW-1:0] LD_READ    = TW'(READ_CYCLES - 1);
    localparam logic [TW-1:0] LD_SKEW    = TW'(SKEW_LEN - 1);
    localparam logic [TW-1:0] LD_SHIFT   = TW'(SHIFT_CYCLES - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(SQRT_P - 1);

    state_e        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic          perr_q, perr_d;
    logic          tmr_load;
    logic [TW-1:0] tmr_val, tmr_cnt;
    logic          tmr_exp;
    logic          start_ok;

    assign start_ok = (state_q == ST_IDLE) && start && !abort;

    // Reloading on every transition keeps the timer fresh for whichever timed phase comes next.
    assign tmr_load = (state_d != state_q);

    always_comb begin
        tmr_val = LD_SHIFT;
        if (state_d == ST_LOAD) tmr_val = LD_READ;
        else if (state_d == ST_SKEW) tmr_val = LD_SKEW;
    end

    phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_cnt),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (tmr_exp) state_d = (SQRT_P > 1) ? ST_SKEW : ST_MUL;
            ST_SKEW:  if (tmr_exp) state_d = ST_MUL;
            ST_MUL:   if (mul_done) state_d = ST_SUM;
            ST_SUM:   if (sum_done) state_d = (round_q == LAST_ROUND) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (tmr_exp) state_d = ST_MUL;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    always_comb begin
        round_d = round_q;
        perr_d  = perr_q | (mul_done && state_q != ST_MUL) | (sum_done && state_q != ST_SUM);
        if (abort || start_ok) begin
            round_d = '0;
        end else if (state_q == ST_SHIFT && tmr_exp && round_q != LAST_ROUND) begin
            round_d = round_q + RW'(1);
        end
        if (start_ok) perr_d = 1'b0;
    end

    always_comb begin
        enable_read  = (state_q == ST_LOAD);
        clear_acc    = (state_q == ST_LOAD) && (tmr_cnt == LD_READ);
        enable_skew  = (state_q == ST_SKEW);
        skew_step    = (state_q == ST_SKEW) ? (LAST_ROUND - RW'(tmr_cnt)) : '0;
        enable_mul   = (state_q == ST_MUL);
        enable_sum   = (state_q == ST_SUM);
        enable_shift = (state_q == ST_SHIFT);
        round        = round_q;
        busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done         = (state_q == ST_DONE);
        proto_err    = perr_q;
    end

endmodule

// File: tb/tb_cannon_sched.sv
// tb/tb_cannon_sched.sv - randomized self-checking bench for cannon_sched
module tb_cannon_sched;

    localparam int PH_IDLE = 0, PH_READ = 1, PH_SKEW = 2, PH_MUL = 3, PH_SUM = 4, PH_SHIFT = 5, PH_DONE = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] st = '0, ab = '0, mdn = '0, sdn = '0;

    logic [4:0] en0, en1, en2, en3;
    logic ca0, ca1, ca2, ca3, bz0, bz1, bz2, bz3, dn0, dn1, dn2, dn3, pe0, pe1, pe2, pe3;
    logic [1:0] rd0, sk0;
    logic [2:0] rd1, sk1;
    logic [0:0] rd2, sk2;
    logic [1:0] rd3, sk3;

    int total = 0, bad = 0;
    int sel = 0;
    int P_OF[4] = '{2, 4, 1, 3};
    int R_OF[4] = '{1, 1, 3, 1};
    int mdl[8], sdl[8];
    int exp_ph[$], exp_rd[$], exp_sk[$];
    int start_k = -1, inj_k = -1, abort_k = -1, rst_k = -1;
    int last_lat, last_rd;
    int n_starts = 0, n_done3 = 0;

    logic [4:0] obs_en;
    logic obs_ca, obs_bz, obs_dn, obs_pe;
    int obs_rd, obs_sk;

    always #5 clk = ~clk;

    cannon_sched #(.SQRT_P(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .mul_done(mdn[0]), .sum_done(sdn[0]),
        .enable_read(en0[0]), .clear_acc(ca0), .enable_skew(en0[1]), .skew_step(sk0), .enable_mul(en0[2]),
        .enable_sum(en0[3]), .enable_shift(en0[4]), .round(rd0), .busy(bz0), .done(dn0), .proto_err(pe0));

    cannon_sched #(.SQRT_P(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .mul_done(mdn[1]), .sum_done(sdn[1]),
        .enable_read(en1[0]), .clear_acc(ca1), .enable_skew(en1[1]), .skew_step(sk1), .enable_mul(en1[2]),
        .enable_sum(en1[3]), .enable_shift(en1[4]), .round(rd1), .busy(bz1), .done(dn1), .proto_err(pe1));

    cannon_sched #(.SQRT_P(1), .READ_CYCLES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .abort(ab[2]), .mul_done(mdn[2]), .sum_done(sdn[2]),
        .enable_read(en2[0]), .clear_acc(ca2), .enable_skew(en2[1]), .skew_step(sk2), .enable_mul(en2[2]),
        .enable_sum(en2[3]), .enable_shift(en2[4]), .round(rd2), .busy(bz2), .done(dn2), .proto_err(pe2));

    cannon_sched #(.SQRT_P(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .abort(ab[3]), .mul_done(mdn[3]), .sum_done(sdn[3]),
        .enable_read(en3[0]), .clear_acc(ca3), .enable_skew(en3[1]), .skew_step(sk3), .enable_mul(en3[2]),
        .enable_sum(en3[3]), .enable_shift(en3[4]), .round(rd3), .busy(bz3), .done(dn3), .proto_err(pe3));

    always_comb begin
        obs_en = en0; obs_ca = ca0; obs_bz = bz0; obs_dn = dn0; obs_pe = pe0;
        obs_rd = int'(rd0); obs_sk = int'(sk0);
        case (sel)
            1: begin obs_en = en1; obs_ca = ca1; obs_bz = bz1; obs_dn = dn1; obs_pe = pe1; obs_rd = int'(rd1); obs_sk = int'(sk1); end
            2: begin obs_en = en2; obs_ca = ca2; obs_bz = bz2; obs_dn = dn2; obs_pe = pe2; obs_rd = int'(rd2); obs_sk = int'(sk2); end
            3: begin obs_en = en3; obs_ca = ca3; obs_bz = bz3; obs_dn = dn3; obs_pe = pe3; obs_rd = int'(rd3); obs_sk = int'(sk3); end
            default: ;
        endcase
    end

    // At most one phase enable per instance in every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (!($onehot0(en0) && $onehot0(en1) && $onehot0(en2) && $onehot0(en3))) begin
                bad++;
                $display("FAIL exclusion: en=%b %b %b %b required onehot0", en0, en1, en2, en3);
            end
            if (dn3) n_done3++;
        end
    end

    // Expected per-cycle phase/round/skew list, index 1 = first cycle after the start edge.
    task automatic build(input int p, input int rc);
        exp_ph.delete(); exp_rd.delete(); exp_sk.delete();
        exp_ph.push_back(PH_IDLE); exp_rd.push_back(0); exp_sk.push_back(0);
        repeat (rc) begin exp_ph.push_back(PH_READ); exp_rd.push_back(0); exp_sk.push_back(0); end
        for (int j = 1; j < p; j++) begin exp_ph.push_back(PH_SKEW); exp_rd.push_back(0); exp_sk.push_back(j); end
        for (int r = 0; r < p; r++) begin
            repeat (mdl[r] + 1) begin exp_ph.push_back(PH_MUL); exp_rd.push_back(r); exp_sk.push_back(0); end
            repeat (sdl[r] + 1) begin exp_ph.push_back(PH_SUM); exp_rd.push_back(r); exp_sk.push_back(0); end
            if (r < p - 1) begin exp_ph.push_back(PH_SHIFT); exp_rd.push_back(r); exp_sk.push_back(0); end
        end
        exp_ph.push_back(PH_DONE); exp_rd.push_back(p - 1); exp_sk.push_back(0);
        exp_ph.push_back(PH_IDLE); exp_rd.push_back(p - 1); exp_sk.push_back(0);
    endtask

    function automatic int find(input int ph, input int rd);
        for (int k = 1; k < exp_ph.size(); k++)
            if (exp_ph[k] == ph && exp_rd[k] == rd) return k;
        return -1;
    endfunction

    task automatic run(input int s, input string nm);
        int n, p;
        logic [7:0] e_ctl, o_ctl;
        logic e_pe;
        p = P_OF[s];
        n = exp_ph.size() - 2;
        sel = s;
        last_lat = -1;
        last_rd = -1;
        @(negedge clk);
        st[s] = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            st[s] = (k == start_k);
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                total++;
                if ({obs_en, obs_ca, obs_bz, obs_dn, obs_pe} !== 9'b0 || obs_rd != 0 || obs_sk != 0) begin
                    bad++;
                    $display("FAIL %s async_reset: en=%b ca=%b busy=%b done=%b perr=%b round=%0d skew=%0d required all 0",
                             nm, obs_en, obs_ca, obs_bz, obs_dn, obs_pe, obs_rd, obs_sk);
                end
                st = '0; ab = '0; mdn = '0; sdn = '0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (abort_k > 0 && k == abort_k + 1) begin
                ab = '0; mdn = '0; sdn = '0;
                total++;
                if ({obs_en, obs_ca, obs_bz, obs_dn} !== 8'b0 || obs_rd != 0) begin
                    bad++;
                    $display("FAIL %s abort: en=%b busy=%b done=%b round=%0d required all 0", nm, obs_en, obs_bz, obs_dn, obs_rd);
                end
                return;
            end
            e_ctl = {((exp_ph[k] >= PH_READ && exp_ph[k] <= PH_SHIFT) ? 5'(1 << (exp_ph[k] - 1)) : 5'b0),
                     1'(k == 1), 1'(k < n), 1'(k == n)};
            o_ctl = {obs_en, obs_ca, obs_bz, obs_dn};
            e_pe = (inj_k > 0 && k > inj_k);
            if (k > n) e_ctl = 8'b0;
            total += 4;
            if (o_ctl !== e_ctl) begin
                bad++;
                $display("FAIL %s ctl cyc%0d: {en,clr,busy,done}=%b required %b", nm, k, o_ctl, e_ctl);
            end
            if (obs_rd != exp_rd[k]) begin
                bad++;
                $display("FAIL %s round cyc%0d: %0d required %0d", nm, k, obs_rd, exp_rd[k]);
            end
            if (obs_sk != exp_sk[k]) begin
                bad++;
                $display("FAIL %s skew_step cyc%0d: %0d required %0d", nm, k, obs_sk, exp_sk[k]);
            end
            if (obs_pe !== e_pe) begin
                bad++;
                $display("FAIL %s proto_err cyc%0d: %b required %b", nm, k, obs_pe, e_pe);
            end
            if (obs_dn && last_lat < 0) begin last_lat = k; last_rd = obs_rd; end
            mdn[s] = (exp_ph[k] == PH_MUL && exp_ph[k + 1] != PH_MUL);
            sdn[s] = (exp_ph[k] == PH_SUM && exp_ph[k + 1] != PH_SUM) || (k == inj_k);
            ab[s]  = (k == abort_k);
        end
        st = '0; mdn = '0; sdn = '0; ab = '0;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 8; i++) begin mdl[i] = 0; sdl[i] = 0; end
        start_k = -1; inj_k = -1; abort_k = -1; rst_k = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({en0, en1, en2, en3, ca0, ca1, ca2, ca3, bz0, bz1, bz2, bz3, dn0, dn1, dn2, dn3, pe0, pe1, pe2, pe3} !== '0 ||
            {rd0, rd1, rd2, rd3, sk0, sk1, sk2, sk3} !== '0) begin
            bad++;
            $display("FAIL reset_state: some output nonzero during reset (en0=%b en1=%b en2=%b en3=%b)", en0, en1, en2, en3);
        end
        rst_n = 1'b1;
        clear_cfg();
        build(2, 1);
        rst_k = find(PH_SHIFT, 0);
        run(0, "reset_mid_shift");
        clear_cfg();
        build(2, 1);
        run(0, "first_run");
        total += 2;
        if (last_lat != 8) begin bad++; $display("FAIL first_run latency: %0d required 8", last_lat); end
        if (last_rd != 1) begin bad++; $display("FAIL first_run done_round: %0d required 1", last_rd); end
    endtask

    task automatic test_stall_mul();
        clear_cfg();
        mdl[0] = 5;
        build(2, 1);
        run(0, "stall_mul");
    endtask

    task automatic test_abort();
        clear_cfg();
        sdl[1] = 3;
        build(4, 1);
        abort_k = find(PH_SUM, 1) + 1;
        run(1, "abort");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (dn1 !== 1'b0 || bz1 !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet cyc%0d: done=%b busy=%b required 0 0", i, dn1, bz1);
            end
        end
        clear_cfg();
        build(4, 1);
        run(1, "after_abort");
        total++;
        if (last_lat != 1 + 3 + 3 * 4 - 1 + 1) begin bad++; $display("FAIL after_abort latency: %0d required 16", last_lat); end
    endtask

    task automatic test_proto_err();
        clear_cfg();
        build(2, 1);
        inj_k = find(PH_SHIFT, 0);
        start_k = find(PH_MUL, 0);
        run(0, "proto_err");
        clear_cfg();
        build(2, 1);
        run(0, "proto_clear");
    endtask

    task automatic test_edge_p1();
        clear_cfg();
        build(1, 3);
        run(2, "p1_read3");
        total++;
        if (last_lat != 6) begin bad++; $display("FAIL p1_read3 latency: %0d required 6", last_lat); end
    endtask

    task automatic test_random_p3();
        int d0;
        d0 = n_done3;
        for (int i = 0; i < 200; i++) begin
            clear_cfg();
            for (int r = 0; r < 3; r++) begin
                mdl[r] = int'($urandom_range(0, 7));
                sdl[r] = int'($urandom_range(0, 7));
            end
            build(3, 1);
            n_starts++;
            run(3, "rand_p3");
        end
        @(negedge clk);
        total++;
        if (n_done3 - d0 != n_starts) begin
            bad++;
            $display("FAIL rand_p3 done_count: %0d required %0d", n_done3 - d0, n_starts);
        end
    endtask

    initial begin
        test_reset();
        test_stall_mul();
        test_abort();
        test_proto_err();
        test_edge_p1();
        test_random_p3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
